// File: rtl/fp_round_pack.sv
// fp_round_pack: final stage of the shared FP32 / dual-FP16 adder datapath.
// Takes the normalizer output plus per-lane shift counts, rounds to nearest-even,
// adjusts exponents, resolves NaN/Inf/zero/overflow/underflow and packs IEEE words.
// Two-stage pipeline (S1: round decision + classification, S2: packed result),
// latency 2, throughput 1/cycle, valid/ready on both sides with bubble collapse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready combinational from out_ready)
//   fmt                      FP32 (single lane) or FP16 (two lanes)
//   norm_r                   normalized 28-bit significand field(s)
//   count_h/l, exp_h/l       normalizer shift counts and pre-normalization exponents
//   sign_h/l, sticky_h/l     per-lane sign and alignment sticky
//   nan_h/l, inf_h/l         special-result overrides
//   out_valid/out_ready      output handshake
//   res                      packed result (FP16: {res_h, res_l})
//   flags_h/l                {ovf, uf, inexact}; FP32 reports on flags_l

package FPALL_pkg;
  typedef enum logic {FP32 = 1'b0, FP16 = 1'b1} fp_fmt_e;
endpackage

module fp_round_pack
  import FPALL_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  fp_fmt_e     fmt,
  input  logic [27:0] norm_r,
  input  logic [4:0]  count_h,
  input  logic [4:0]  count_l,
  input  logic [9:0]  exp_h,
  input  logic [9:0]  exp_l,
  input  logic        sign_h,
  input  logic        sign_l,
  input  logic        sticky_h,
  input  logic        sticky_l,
  input  logic        nan_h,
  input  logic        nan_l,
  input  logic        inf_h,
  input  logic        inf_l,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic [2:0]  flags_h,
  output logic [2:0]  flags_l
);

  typedef enum logic [2:0] {
    C_NORM, C_ZERO, C_NAN, C_INF, C_OVF, C_UF
  } lane_cls_e;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_v, s2_v;
  logic advance;

  assign advance   = !s2_v || out_ready;
  assign in_ready  = !s1_v || advance;
  assign out_valid = s2_v;

  // ---------------------------------------------------------------------------
  // S1 combinational: field extraction and rounding.
  // The low lane serves both FP32 and the FP16 low half; the high lane is
  // only meaningful in FP16.
  // ---------------------------------------------------------------------------
  logic        is32;
  logic [23:0] l_sig;
  logic        l_g, l_s, l_inc, l_carry, l_zero, l_ovf, l_uf, l_inx;
  logic [9:0]  l_e, l_ef;
  logic [22:0] l_frac;
  lane_cls_e   l_cls;

  logic [10:0] h_sig;
  logic        h_g, h_s, h_inc, h_carry, h_zero, h_ovf, h_uf, h_inx;
  logic [9:0]  h_e, h_ef;
  logic [9:0]  h_frac;
  lane_cls_e   h_cls;

  assign is32 = (fmt == FP32);

  always_comb begin
    l_sig = '0;
    l_g   = 1'b0;
    l_s   = 1'b0;
    if (is32) begin
      l_sig = norm_r[27:4];
      l_g   = norm_r[3];
      l_s   = (|norm_r[2:0]) | sticky_l;
    end else begin
      l_sig = {13'd0, norm_r[13:3]};
      l_g   = norm_r[2];
      l_s   = (|norm_r[1:0]) | sticky_l;
    end
  end

  assign h_sig = norm_r[27:17];
  assign h_g   = norm_r[16];
  assign h_s   = (|norm_r[15:14]) | sticky_h;

  assign l_e = exp_l - {5'd0, count_l};
  assign h_e = exp_h - {5'd0, count_h};

  assign l_inc = l_g & (l_s | l_sig[0]);
  assign h_inc = h_g & (h_s | h_sig[0]);

  // Carry-out only happens when every significand bit is set. The fraction
  // adder then wraps to zero, which is exactly the 1.0 significand we want,
  // so the hidden bit never needs to be stored.
  assign l_carry = l_inc & (is32 ? (&l_sig) : (&l_sig[10:0]));
  assign h_carry = h_inc & (&h_sig);

  assign l_frac = l_sig[22:0] + {22'd0, l_inc};
  assign h_frac = h_sig[9:0] + {9'd0, h_inc};

  assign l_ef = l_carry ? l_e + 10'd1 : l_e;
  assign h_ef = h_carry ? h_e + 10'd1 : h_e;

  assign l_zero = (l_sig == '0) && !l_s;
  assign h_zero = (h_sig == '0) && !h_s;

  assign l_ovf = is32 ? ($signed(l_ef) >= 10'sd255) : ($signed(l_ef) >= 10'sd31);
  assign h_ovf = $signed(h_ef) >= 10'sd31;
  assign l_uf  = $signed(l_ef) <= 10'sd0;
  assign h_uf  = $signed(h_ef) <= 10'sd0;

  always_comb begin
    l_cls = C_NORM;
    if (nan_l)       l_cls = C_NAN;
    else if (inf_l)  l_cls = C_INF;
    else if (l_zero) l_cls = C_ZERO;
    else if (l_ovf)  l_cls = C_OVF;
    else if (l_uf)   l_cls = C_UF;
  end

  always_comb begin
    h_cls = C_NORM;
    if (nan_h)       h_cls = C_NAN;
    else if (inf_h)  h_cls = C_INF;
    else if (h_zero) h_cls = C_ZERO;
    else if (h_ovf)  h_cls = C_OVF;
    else if (h_uf)   h_cls = C_UF;
  end

  // A flushed result discards the whole significand, so any set bit is inexact.
  assign l_inx = (l_cls == C_UF) ? ((|l_sig) | l_g | l_s) : (l_g | l_s);
  assign h_inx = (h_cls == C_UF) ? ((|h_sig) | h_g | h_s) : (h_g | h_s);

  // ---------------------------------------------------------------------------
  // S1 registers
  // ---------------------------------------------------------------------------
  fp_fmt_e     s1_fmt;
  lane_cls_e   s1_cls_l, s1_cls_h;
  logic        s1_sign_l, s1_sign_h, s1_inx_l, s1_inx_h;
  logic [7:0]  s1_e_l;
  logic [4:0]  s1_e_h;
  logic [22:0] s1_frac_l;
  logic [9:0]  s1_frac_h;

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_fmt    <= fmt;
      s1_cls_l  <= l_cls;
      s1_cls_h  <= h_cls;
      s1_sign_l <= sign_l;
      s1_sign_h <= sign_h;
      s1_inx_l  <= l_inx;
      s1_inx_h  <= h_inx;
      s1_e_l    <= l_ef[7:0];
      s1_e_h    <= h_ef[4:0];
      s1_frac_l <= l_frac;
      s1_frac_h <= h_frac;
    end
  end

  // ---------------------------------------------------------------------------
  // S2 combinational: packing
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] pack16(lane_cls_e c, logic s, logic [4:0] e,
                                         logic [9:0] f);
    case (c)
      C_NAN:        return 16'h7E00;
      C_INF, C_OVF: return {s, 5'h1F, 10'd0};
      C_ZERO, C_UF: return {s, 15'd0};
      default:      return {s, e, f};
    endcase
  endfunction

  function automatic logic [2:0] lane_flags(lane_cls_e c, logic inx);
    case (c)
      C_OVF:   return 3'b101;
      C_UF:    return {2'b01, inx};
      C_NORM:  return {2'b00, inx};
      default: return 3'b000;
    endcase
  endfunction

  logic [31:0] pk_res;
  logic [2:0]  pk_fh, pk_fl;

  always_comb begin
    pk_res = '0;
    pk_fh  = '0;
    pk_fl  = lane_flags(s1_cls_l, s1_inx_l);
    if (s1_fmt == FP32) begin
      case (s1_cls_l)
        C_NAN:        pk_res = 32'h7FC0_0000;
        C_INF, C_OVF: pk_res = {s1_sign_l, 8'hFF, 23'd0};
        C_ZERO, C_UF: pk_res = {s1_sign_l, 31'd0};
        default:      pk_res = {s1_sign_l, s1_e_l, s1_frac_l};
      endcase
    end else begin
      pk_res = {pack16(s1_cls_h, s1_sign_h, s1_e_h, s1_frac_h),
                pack16(s1_cls_l, s1_sign_l, s1_e_l[4:0], s1_frac_l[9:0])};
      pk_fh  = lane_flags(s1_cls_h, s1_inx_h);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage valids and S2 output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      res     <= '0;
      flags_h <= '0;
      flags_l <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (advance)  s2_v <= s1_v;
      if (advance && s1_v) begin
        res     <= pk_res;
        flags_h <= pk_fh;
        flags_l <= pk_fl;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: self-checking bench for fp_round_pack.
// Directed cases for exact values, rounding, specials, backpressure and reset,
// then randomized traffic scored against an arithmetic reference model.

module tb_fp_round_pack;
  import FPALL_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  fp_fmt_e     fmt;
  logic [27:0] norm_r;
  logic [4:0]  count_h, count_l;
  logic [9:0]  exp_h, exp_l;
  logic        sign_h, sign_l, sticky_h, sticky_l;
  logic        nan_h, nan_l, inf_h, inf_l;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [2:0]  flags_h, flags_l;

  always #5 clk = ~clk;

  fp_round_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .norm_r(norm_r), .count_h(count_h), .count_l(count_l), .exp_h(exp_h),
    .exp_l(exp_l), .sign_h(sign_h), .sign_l(sign_l), .sticky_h(sticky_h),
    .sticky_l(sticky_l), .nan_h(nan_h), .nan_l(nan_l), .inf_h(inf_h),
    .inf_l(inf_l), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .flags_h(flags_h), .flags_l(flags_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the rounding rules
  // ---------------------------------------------------------------------------
  function automatic int wrap10(input int x);
    int y;
    y = x & 1023;
    if (y >= 512) y -= 1024;
    return y;
  endfunction

  function automatic void lane_model(input int w, input longint sig_in, input bit g,
                                     input bit s, input int e_in, input bit sign,
                                     input bit nan, input bit inf,
                                     output longint bits, output logic [2:0] fl);
    int     tot, emax, e;
    longint sig, half, sgn, infv;
    bit     lost;
    tot  = (w == 24) ? 32 : 16;
    emax = (w == 24) ? 255 : 31;
    half = longint'(1) << (w - 1);
    sgn  = sign ? (longint'(1) << (tot - 1)) : 0;
    infv = sgn + longint'(emax) * half;
    sig  = sig_in;
    e    = e_in;
    fl   = 3'b000;
    lost = (sig_in != 0) || g || s;
    if (nan)                 bits = (w == 24) ? 64'h7FC00000 : 64'h7E00;
    else if (inf)            bits = infv;
    else if (sig == 0 && !s) bits = sgn;
    else begin
      if (g && (s || (sig % 2 == 1))) sig++;
      if (sig == 2 * half) begin
        sig = half;
        e   = wrap10(e + 1);
      end
      if (e >= emax) begin
        bits = infv;
        fl   = 3'b101;
      end else if (e <= 0) begin
        bits = sgn;
        fl   = {2'b01, lost};
      end else begin
        bits = sgn + longint'(e) * half + (sig % half);
        fl   = {2'b00, g || s};
      end
    end
  endfunction

  // returns {flags_h, flags_l, res} for the inputs currently driven
  function automatic logic [37:0] model_now();
    longint      bl, bh;
    logic [2:0]  fl, fh;
    int          el, eh;
    el = wrap10(int'($signed(exp_l)) - int'(count_l));
    eh = wrap10(int'($signed(exp_h)) - int'(count_h));
    if (fmt == FP32) begin
      lane_model(24, longint'(norm_r[27:4]), norm_r[3], (|norm_r[2:0]) | sticky_l,
                 el, sign_l, nan_l, inf_l, bl, fl);
      return {3'b000, fl, bl[31:0]};
    end
    lane_model(11, longint'(norm_r[27:17]), norm_r[16], (|norm_r[15:14]) | sticky_h,
               eh, sign_h, nan_h, inf_h, bh, fh);
    lane_model(11, longint'(norm_r[13:3]), norm_r[2], (|norm_r[1:0]) | sticky_l,
               el, sign_l, nan_l, inf_l, bl, fl);
    return {fh, fl, bh[15:0], bl[15:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle stepping with scoreboard
  // ---------------------------------------------------------------------------
  logic [37:0] sb_q[$];
  int          acc_q[$];
  int          cyc = 0;
  bit          acc, fired, stall_prev;
  logic [38:0] hold_val;
  logic [31:0] last_res;
  logic [5:0]  last_fl;

  task automatic step();
    logic [37:0] e;
    @(negedge clk);
    acc   = 0;
    fired = 0;
    if (rst) begin
      sb_q.delete();
      acc_q.delete();
      stall_prev = 0;
    end else begin
      if (stall_prev) check("hold", {out_valid, flags_h, flags_l, res}, hold_val);
      check("in_ready", 64'(in_ready), 64'(!(sb_q.size() == 2 && !out_ready)));
      check("out_valid", 64'(out_valid),
            64'(sb_q.size() > 0 && (cyc - acc_q[0]) >= 2));
      if (out_valid && out_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        void'(acc_q.pop_front());
        check("res", res, e[31:0]);
        check("flags", {flags_h, flags_l}, e[37:32]);
        fired    = 1;
        last_res = res;
        last_fl  = {flags_h, flags_l};
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model_now());
        acc_q.push_back(cyc);
        acc = 1;
      end
      stall_prev = out_valid && !out_ready;
      hold_val   = {out_valid, flags_h, flags_l, res};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_in();
    in_valid = 0; fmt = FP32; norm_r = '0;
    count_h = '0; count_l = '0; exp_h = '0; exp_l = '0;
    sign_h = 0; sign_l = 0; sticky_h = 0; sticky_l = 0;
    nan_h = 0; nan_l = 0; inf_h = 0; inf_l = 0;
  endtask

  // Offer the currently driven transaction into an empty pipe, expect it after 2 cycles.
  task automatic run_one(input string tag, input logic [31:0] exp_res, input logic [5:0] exp_fl);
    int lat;
    lat       = -1;
    in_valid  = 1;
    out_ready = 1;
    step();
    check({tag, "_acc"}, 64'(acc), 64'd1);
    in_valid = 0;
    for (int i = 1; i <= 6 && lat < 0; i++) begin
      step();
      if (fired) lat = i;
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_res"}, last_res, exp_res);
    check({tag, "_flags"}, last_fl, exp_fl);
  endtask

  task automatic rand_txn();
    fmt    = ($urandom_range(0, 1) != 0) ? FP16 : FP32;
    norm_r = 28'($urandom);
    if ($urandom_range(0, 3) != 0) begin norm_r[27] = 1; norm_r[13] = 1; end
    if ($urandom_range(0, 7) == 0) norm_r[26:4] = '1;
    if ($urandom_range(0, 15) == 0) norm_r = '0;
    count_h  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    count_l  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    exp_h    = 10'($urandom_range(0, 35));
    exp_l    = (fmt == FP32) ? 10'($urandom_range(0, 260)) : 10'($urandom_range(0, 35));
    if ($urandom_range(0, 9) == 0) exp_l = 10'($urandom);
    if ($urandom_range(0, 9) == 0) exp_h = 10'($urandom);
    sign_h   = 1'($urandom);
    sign_l   = 1'($urandom);
    sticky_h = 1'($urandom);
    sticky_l = 1'($urandom);
    nan_h    = ($urandom_range(0, 15) == 0);
    nan_l    = ($urandom_range(0, 15) == 0);
    inf_h    = ($urandom_range(0, 15) == 0);
    inf_l    = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [27:0] bp_norm [3];
    int          idx, nfired, last_fire;
    stall_prev = 0;
    clear_in();
    out_ready = 1;
    rst       = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", res, 32'h0);
    check("rst_flags", {flags_h, flags_l}, 6'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // exact 1.0
    clear_in(); norm_r = 28'h8000000; exp_l = 10'd127;
    run_one("fp32_one", 32'h3F800000, 6'b000_000);
    // rounding carry and tie-to-even
    clear_in(); norm_r = 28'hFFFFFF8; exp_l = 10'd127;
    run_one("fp32_carry", 32'h40000000, 6'b000_001);
    clear_in(); norm_r = 28'h8000008; exp_l = 10'd127;
    run_one("fp32_tie", 32'h3F800000, 6'b000_001);
    // dual FP16
    clear_in(); fmt = FP16; norm_r = {14'h2000, 14'h2000};
    exp_h = 10'd15; count_l = 5'd1; exp_l = 10'd17;
    run_one("fp16_dual", 32'h3C004000, 6'b000_000);
    // overflow
    clear_in(); norm_r = 28'h8000000; exp_l = 10'd255; sign_l = 1;
    run_one("fp32_ovf", 32'hFF800000, 6'b000_101);
    // FP16 low-lane underflow
    clear_in(); fmt = FP16; norm_r = {14'h2000, 14'h2000}; exp_h = 10'd15; exp_l = 10'd0;
    run_one("fp16_uf", 32'h3C000000, 6'b000_011);
    // NaN override on the high lane
    clear_in(); fmt = FP16; norm_r = {14'h2000, 14'h2000}; exp_l = 10'd15; nan_h = 1;
    run_one("fp16_nan", 32'h7E003C00, 6'b000_000);

    // backpressure: three offers, only two fit
    bp_norm = '{28'h8000000, 28'h9000000, 28'hA000000};
    clear_in(); exp_l = 10'd127;
    out_ready = 0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (idx < 3);
      if (idx < 3) norm_r = bp_norm[idx];
      step();
      if (acc) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    nfired    = 0;
    last_fire = -1;
    for (int i = 0; i < 10 && nfired < 3; i++) begin
      in_valid = (idx < 3);
      if (idx < 3) norm_r = bp_norm[idx];
      step();
      if (acc) idx++;
      if (fired) begin
        if (last_fire >= 0) check("bp_gap", 64'((i - last_fire) <= 2), 64'd1);
        last_fire = i;
        nfired++;
      end
    end
    in_valid = 0;
    check("bp_drained", 64'(nfired), 64'd3);

    // reset with two in flight
    clear_in(); norm_r = 28'h8000000; exp_l = 10'd100;
    out_ready = 0;
    in_valid  = 1;
    step();
    step();
    in_valid = 0;
    rst = 1;
    step();
    rst = 0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_res", res, 32'h0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    clear_in(); norm_r = 28'h8000000; exp_l = 10'd127;
    run_one("post_rst", 32'h3F800000, 6'b000_000);

    // randomized traffic
    clear_in();
    for (int i = 0; i < 800; i++) begin
      if (!in_valid || acc) begin
        rand_txn();
        in_valid = ($urandom_range(0, 4) != 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) step();
    check("final_drain", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
